// File: rtl/bka_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bka_arb_pkg
// Description : Shared constants and types for the round-robin shared
//               Brent-Kung adder block (requester count, operand width,
//               requester index width, arbitration state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package bka_arb_pkg;

    localparam int N_REQ = 4;   // number of requesters (fixed)
    localparam int W     = 10;  // operand width, matches the 10-bit adder core
    localparam int ID_W  = 2;   // requester index width

    // ARB   : normal round-robin arbitration
    // CHAIN : grant locked to one requester, carry chained between words
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CHAIN = 1'b1
    } state_t;

endpackage : bka_arb_pkg
`default_nettype wire

// File: rtl/UBPriBKA_9_0.sv
`default_nettype none
// ============================================================================
// Module      : UBPriBKA_9_0
// Description : 10-bit unsigned Brent-Kung prefix adder with carry-in.
//               S = X + Y + Cin, full 11-bit result (S[10] is carry-out).
// Ports       : X[9:0], Y[9:0]  operands
//               Cin             carry-in
//               S[10:0]         sum with carry-out in the MSB
// Revision    : 1.0 - initial release
// ============================================================================
module UBPriBKA_9_0 (
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic        Cin,
    output logic [10:0] S
);

    logic [9:0] w_p;   // bitwise propagate
    logic [9:0] w_g;   // group generate, ends up as carry out of bits [i:0]
    logic [9:0] w_pp;  // group propagate

    always_comb begin
        w_p  = X ^ Y;
        w_pp = w_p;
        w_g  = X & Y;
        // Folding the carry-in into bit 0 makes every prefix include it,
        // so w_g[i] becomes the carry into bit i+1.
        w_g[0] = w_g[0] | (w_p[0] & Cin);

        // Up-sweep: build power-of-two spans ending at nodes 2s-1, 4s-1, ...
        for (int l = 0; l < 4; l++) begin
            for (int i = (2 << l) - 1; i < 10; i += (2 << l)) begin
                w_g[i]  = w_g[i] | (w_pp[i] & w_g[i - (1 << l)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
            end
        end

        // Down-sweep: fill in the remaining prefixes from already-complete ones.
        for (int l = 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < 10; i += (2 << l)) begin
                w_g[i]  = w_g[i] | (w_pp[i] & w_g[i - (1 << l)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << l)];
            end
        end
    end

    assign S[0]   = w_p[0] ^ Cin;
    assign S[9:1] = w_p[9:1] ^ w_g[8:0];
    assign S[10]  = w_g[9];

endmodule : UBPriBKA_9_0
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Combinational one-hot round-robin grant for four requesters.
//               The search starts at prio_ptr; when lock is high the grant
//               is forced to lock_id (and is empty if lock_id is idle).
// Ports       : req_valid[3:0]  request vector
//               prio_ptr[1:0]   highest-priority requester this cycle
//               lock            force grant to lock_id
//               lock_id[1:0]    locked requester
//               grant[3:0]      one-hot grant (all zero when nothing granted)
//               grant_id[1:0]   index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
    import bka_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  prio_ptr,
    input  logic             lock,
    input  logic [ID_W-1:0]  lock_id,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    always_comb begin
        logic [ID_W-1:0] idx;
        grant    = '0;
        grant_id = '0;
        idx      = '0;
        if (lock) begin
            if (req_valid[lock_id]) begin
                grant[lock_id] = 1'b1;
                grant_id       = lock_id;
            end
        end else begin
            // Scan from the farthest position back to prio_ptr so the last
            // hit (the closest to prio_ptr) wins.
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = prio_ptr + ID_W'(k);
                if (req_valid[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_id   = idx;
                end
            end
        end
    end

endmodule : rr_arbiter_4
`default_nettype wire

// File: rtl/bka_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bka_add_arbiter
// Description : One 10-bit Brent-Kung adder shared round-robin by four
//               valid/ready requesters. Results are registered in a
//               one-entry output stage with back-pressure and tagged with
//               the requester index.
//               Optional macro BKA_ARB_CHAIN_EN: a beat with req_last=0 locks
//               the adder to that requester and chains the carry between
//               words until a beat with req_last=1.
// Ports       : clk, rst (sync, active-high)
//               req_valid/req_ready[3:0], req_x/req_y[39:0] (10 bits each),
//               req_cin[3:0], req_last[3:0]
//               rsp_valid, rsp_ready, rsp_sum[10:0], rsp_id[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module bka_add_arbiter
    import bka_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    input  logic [N_REQ-1:0]   req_cin,
    input  logic [N_REQ-1:0]   req_last,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W:0]         rsp_sum,
    output logic [ID_W-1:0]    rsp_id
);

    logic [ID_W-1:0]  r_prio_ptr;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_can_load;
    logic             w_xfer;
    logic             w_lock;
    logic [ID_W-1:0]  w_lock_id;
    logic             w_cin;
    logic [W-1:0]     w_x;
    logic [W-1:0]     w_y;
    logic [W:0]       w_sum;

`ifdef BKA_ARB_CHAIN_EN
    state_t           r_state;
    logic             r_carry_q;
    logic [ID_W-1:0]  r_lock_id;

    assign w_lock    = (r_state == CHAIN);
    assign w_lock_id = r_lock_id;
    // Inside a chain the carry comes from the previous word, not the requester.
    assign w_cin     = w_lock ? r_carry_q : req_cin[w_grant_id];
`else
    logic             w_unused_last;

    assign w_lock        = 1'b0;
    assign w_lock_id     = '0;
    assign w_cin         = req_cin[w_grant_id];
    assign w_unused_last = ^req_last;
`endif

    // Output register can take a new result when empty or being drained.
    assign w_can_load = !rsp_valid | rsp_ready;

    rr_arbiter_4 u_arb (
        .req_valid (req_valid),
        .prio_ptr  (r_prio_ptr),
        .lock      (w_lock),
        .lock_id   (w_lock_id),
        .grant     (w_grant),
        .grant_id  (w_grant_id)
    );

    assign req_ready = w_grant & {N_REQ{w_can_load & !rst}};
    assign w_xfer    = |req_ready;

    assign w_x = req_x[w_grant_id*W +: W];
    assign w_y = req_y[w_grant_id*W +: W];

    UBPriBKA_9_0 u_add (
        .X   (w_x),
        .Y   (w_y),
        .Cin (w_cin),
        .S   (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_id     <= '0;
            r_prio_ptr <= '0;
`ifdef BKA_ARB_CHAIN_EN
            r_state    <= ARB;
            r_carry_q  <= 1'b0;
            r_lock_id  <= '0;
`endif
        end else begin
            if (w_xfer) begin
                rsp_valid  <= 1'b1;
                rsp_sum    <= w_sum;
                rsp_id     <= w_grant_id;
                r_prio_ptr <= w_grant_id + 1'b1;
`ifdef BKA_ARB_CHAIN_EN
                r_carry_q  <= w_sum[W];
                case (r_state)
                    ARB: begin
                        if (!req_last[w_grant_id]) begin
                            r_state   <= CHAIN;
                            r_lock_id <= w_grant_id;
                        end
                    end
                    CHAIN: begin
                        if (req_last[w_grant_id]) begin
                            r_state    <= ARB;
                            r_prio_ptr <= r_lock_id + 1'b1;
                        end
                    end
                    default: r_state <= ARB;
                endcase
`endif
            end else if (rsp_ready) begin
                // Drained with nothing new: sum/id keep their last values.
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule : bka_add_arbiter
`default_nettype wire

// File: tb/tb_bka_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bka_add_arbiter
// Description : Self-checking bench for bka_add_arbiter. Directed stimulus
//               pushes hand-computed {id, sum} expectations into a queue; a
//               monitor pops and compares on every response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bka_add_arbiter;
    import bka_arb_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_x;
    logic [N_REQ*W-1:0] req_y;
    logic [N_REQ-1:0]   req_cin;
    logic [N_REQ-1:0]   req_last;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [W:0]         rsp_sum;
    logic [ID_W-1:0]    rsp_id;

    int n_checks = 0;
    int n_err    = 0;
    logic [12:0] exp_q[$];   // {id[1:0], sum[10:0]}

    always #5 clk = ~clk;

    bka_add_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic cin, input logic last);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_cin[i]      = cin;
        req_last[i]     = last;
    endtask

    task automatic push(input logic [1:0] id, input logic [10:0] sum);
        exp_q.push_back({id, sum});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the negedge where requester i is being accepted.
    task automatic wait_rdy(input int i, input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req_ready[i] && cyc < 30);
        if (!req_ready[i]) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: timeout waiting for req_ready[%0d]", name, i);
        end
    endtask

    // Monitor: one-hot ready every cycle, scoreboard compare on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id=%0d sum=0x%0h expected none", rsp_id, rsp_sum);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e[12:11]));
                    check("rsp_sum", 32'(rsp_sum), 32'(e[10:0]));
                end
            end
        end
    end

    initial begin
        int cnt;
        int cyc;
        logic [N_REQ-1:0] rdy;

        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        req_last  = '0;

        // ---------------- Reset with all requesters valid ----------------
        set_req(0, 10'h001, 10'h002, 1'b0, 1'b1);   // 0x003
        set_req(1, 10'h100, 10'h0FF, 1'b1, 1'b1);   // 0x200
        set_req(2, 10'h3FF, 10'h001, 1'b0, 1'b1);   // 0x400
        set_req(3, 10'h200, 10'h300, 1'b0, 1'b1);   // 0x500
        req_valid = 4'hF;
        step();
        step();
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_sum", 32'(rsp_sum), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);

        // ---------------- Fairness: 0,1,2,3,0 ----------------
        push(2'd0, 11'h003);
        push(2'd1, 11'h200);
        push(2'd2, 11'h400);
        push(2'd3, 11'h500);
        push(2'd0, 11'h003);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 5 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (|req_ready) cnt++;
        end
        check("fair_cycles", 32'(cyc), 32'd5);
        step();
        req_valid = '0;
        step();
        step();

        // ---------------- Back-pressure ----------------
        rsp_ready = 1'b0;
        set_req(1, 10'h0AA, 10'h0AB, 1'b0, 1'b1);   // 0x155
        push(2'd1, 11'h155);
        req_valid = 4'b0010;
        wait_rdy(1, "bp_accept");
        step();
        set_req(2, 10'h3FF, 10'h3FF, 1'b1, 1'b1);   // max: 0x7FF
        push(2'd2, 11'h7FF);
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_sum", 32'(rsp_sum), 32'h155);
            check("bp_rsp_id", 32'(rsp_id), 32'h1);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("drain_load_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("no_bubble_valid", 32'(rsp_valid), 32'h1);
        step();
        step();

        // ---------------- Chain stimulus (requester 3, requester 0 waiting) ----
        set_req(0, 10'h010, 10'h020, 1'b0, 1'b1);   // 0x030
        set_req(3, 10'h3FF, 10'h001, 1'b0, 1'b0);   // 0x400, carry-out 1
`ifdef BKA_ARB_CHAIN_EN
        push(2'd3, 11'h400);
        push(2'd3, 11'h001);   // 0 + 0 + chained carry
        push(2'd0, 11'h030);
`else
        push(2'd3, 11'h400);
        push(2'd0, 11'h030);
        push(2'd3, 11'h000);   // independent beat, cin = 0
`endif
        req_valid = 4'b1001;
        cnt = 0;   // words accepted from requester 3
        cyc = 0;
        while (req_valid != 4'b0000 && cyc < 20) begin
            @(negedge clk);
            rdy = req_ready;
            cyc++;
            step();
            if (rdy[3]) begin
                cnt++;
                if (cnt == 1) set_req(3, 10'h000, 10'h000, 1'b0, 1'b1);
                else          req_valid[3] = 1'b0;
            end
            if (rdy[0]) req_valid[0] = 1'b0;
        end
        check("chain_done", 32'(req_valid), 32'h0);
        step();
        step();

        // ---------------- Reset in the middle of a chain ----------------
        rsp_ready = 1'b0;
        set_req(2, 10'h3FF, 10'h3FF, 1'b1, 1'b0);   // 0x7FF, carry-out 1
        req_valid = 4'b0100;
        wait_rdy(2, "rc_accept");
        step();
        req_valid = '0;
        @(negedge clk);
        check("rc_held_valid", 32'(rsp_valid), 32'h1);
        check("rc_held_sum", 32'(rsp_sum), 32'h7FF);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rc_reset_valid", 32'(rsp_valid), 32'h0);
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 10'h000, 10'h000, 1'b0, 1'b1);
        push(2'd0, 11'h000);
        req_valid = 4'b0001;
        wait_rdy(0, "rc_after_reset");
        step();
        req_valid = '0;

        // ---------------- Drain the scoreboard ----------------
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        step();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_bka_add_arbiter
`default_nettype wire

// File: doc/bka_add_arbiter.md
# bka_add_arbiter

Shares one 10-bit Brent-Kung prefix adder with carry-in (UBPriBKA_9_0) among four requesters. Each requester has its own valid/ready channel, and grants rotate round-robin. The block registers each sum in a one-entry output stage with back-pressure and tags it with the requester index. When compiled in, it can lock the adder to one requester so that multi-word operands are added with the carry chained between words.

## Interface
Parameters:
- N_REQ, 4, number of requesters; fixed at 4, so the index is 2 bits wide.
- W, 10, operand width; fixed to match the 10-bit adder core.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit is high in any cycle.
- req_x  in  N_REQ*W  operand X; requester i uses bits [i*W +: W].
- req_y  in  N_REQ*W  operand Y, same packing as req_x.
- req_cin  in  N_REQ  carry-in for requester i.
- req_last  in  N_REQ  marks the last word of a chained operation; ignored without BKA_ARB_CHAIN_EN.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_sum  out  W+1  {carry-out, sum[9:0]}.
- rsp_id  out  2  index of the requester that produced the result.

## Operation
- Beat transfer:
  - A requester beat transfers when req_valid[i] & req_ready[i].
  - The response transfers when rsp_valid & rsp_ready.
- Output stage:
  - The output register can load when it is empty or draining: can_load = !rsp_valid | rsp_ready.
- Grant:
  - Round-robin among the requesters with req_valid high, starting from prio_ptr.
  - req_ready[i] = grant[i] & can_load & !rst. This is combinational from req_valid, the state and rsp_ready.
- Adder input:
  - The adder sees the granted requester's X, Y and carry-in.
  - On a transfer, rsp_sum ← adder S[10:0], rsp_id ← grant index, rsp_valid ← 1.
- Pointer update:
  - On a transfer, prio_ptr ← grant index + 1, wrapping 3 → 0.
  - With no transfer, prio_ptr holds.
- Output clear:
  - If rsp_valid & rsp_ready and there is no new transfer, rsp_valid ← 0.
  - rsp_sum and rsp_id hold their last values.
- Stability:
  - While rsp_valid & !rsp_ready, rsp_sum and rsp_id are held stable.
  - Requesters hold X, Y, cin and last stable while valid & !ready.
- Width rule:
  - The sum is a full 11-bit unsigned result with no truncation; 0x3FF + 0x3FF + 1 = 0x7FF.
- State machine (a single state when the macro is absent):
  - ARB: normal round-robin arbitration.
  - CHAIN: grant is locked to lock_id and carry-in comes from carry_q (see Configuration).
- Reset values: rsp_valid 0, rsp_sum 0, rsp_id 0, req_ready all 0, prio_ptr 0 (requester 0 highest), state ARB, carry_q 0, lock_id 0.
- Reset mid-operation: any held response is discarded and any chain is abandoned. Requesters must restart a chain from its first word.

## Timing
- Latency: an operand accepted in cycle t appears on rsp_* in cycle t+1.
- Throughput: one beat per cycle while rsp_ready is held high.
- Back-pressure: with rsp_valid=1 and rsp_ready=0, all req_ready bits are 0.
- Simultaneous drain and load: if rsp_ready=1 and a new beat transfers in the same cycle, rsp_valid stays 1 with the new data, with no bubble.
- Idle: with no req_valid, grant is none and prio_ptr holds.
- First cycle after rst deasserts: req_ready may assert if requests are present.

## Configuration
- Macro: BKA_ARB_CHAIN_EN.
- Defined:
  - A transfer in ARB with req_last=0 moves to CHAIN, sets lock_id ← grant index and carry_q ← S[10]. The first word uses req_cin.
  - In CHAIN only lock_id can be granted; other requesters wait even if lock_id is idle.
  - Carry-in = carry_q, and req_cin is ignored. Each transfer updates carry_q ← S[10].
  - A transfer with req_last=1 returns to ARB and sets prio_ptr ← lock_id + 1. A last=1 beat in ARB is a single-word operation.
- Not defined:
  - There is no CHAIN state, and req_last is ignored.
  - Every beat is independent and uses req_cin.
  - carry_q and lock_id are not implemented.

## Structure
- Package bka_arb_pkg holds:
  - N_REQ and W.
  - The ID width as localparam ID_W=2.
  - The state enum: ARB and CHAIN.
- One sub-module, rr_arbiter_4:
  - Combinational one-hot round-robin grant from req_valid and prio_ptr.
  - Includes a lock input that forces the grant to lock_id.
- The adder is instantiated directly as UBPriBKA_9_0, with the carry-in port driven by the selected carry.

## Test plan
- Reset: assert rst with all four req_valid high. Required: req_ready=0, rsp_valid=0, rsp_sum=0. First grant after release goes to requester 0.
- Fairness: all four valid continuously with rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0 on consecutive cycles. Requester 2 with X=0x3FF, Y=0x001, cin=0 returns rsp_sum=0x400.
- Back-pressure: rsp_ready=0 for 3 cycles with rsp_valid=1 holding 0x155 (X=0x0AA, Y=0x0AB, cin=0, id 1). Required: all req_ready=0 and rsp_sum/rsp_id stable. rsp_ready=1 then drains and loads the next beat in the same cycle.
- Maximum value: X=0x3FF, Y=0x3FF, cin=1. Required: rsp_sum=0x7FF.
- Chain (macro defined):
  - Requester 3 sends words (0x3FF, 0x001, cin=0, last=0) then (0x000, 0x000, last=1). Requester 0 is valid throughout.
  - Required: sums 0x400 then 0x001 on consecutive cycles, both with id 3. Requester 0 is not granted until after the last word, then prio_ptr=0.
  - Without the macro, the same stimulus interleaves requesters and the second sum is 0x000.
- Reset mid-chain: assert rst after the first chained word. Required: state returns to ARB and carry_q is 0. The next beat (0,0,cin=0) sums to 0x000.
